// File: rtl/mfp_ahb_ram_slave_ws_pkg.sv
// Shared AHB-Lite encodings, slave FSM state codes and byte-lane helpers
// for the wait-state RAM slave.
package mfp_ahb_ram_slave_ws_pkg;

   localparam int BYTE_LANES = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'b000;
   localparam logic [2:0] HSIZE_HALF = 3'b001;
   localparam logic [2:0] HSIZE_WORD = 3'b010;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;
   localparam logic [2:0] HBURST_WRAP4  = 3'b010;
   localparam logic [2:0] HBURST_INCR4  = 3'b011;
   localparam logic [2:0] HBURST_WRAP8  = 3'b100;
   localparam logic [2:0] HBURST_INCR8  = 3'b101;
   localparam logic [2:0] HBURST_WRAP16 = 3'b110;
   localparam logic [2:0] HBURST_INCR16 = 3'b111;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ERR1 = 2'd2;
   localparam logic [1:0] S_ERR2 = 2'd3;

   function automatic logic [BYTE_LANES-1:0] byte_en(input logic [1:0] a, input logic [2:0] size);
      logic [BYTE_LANES-1:0] be;
      case (size)
         HSIZE_BYTE: be = 4'b0001 << a;
         HSIZE_HALF: be = a[1] ? 4'b1100 : 4'b0011;
         default:    be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic size_err(input logic [1:0] a, input logic [2:0] size);
      return (size > HSIZE_WORD) ||
             ((size == HSIZE_HALF) && a[0]) ||
             ((size == HSIZE_WORD) && (a != 2'b00));
   endfunction

endpackage

// File: rtl/mfp_ahb_ram_slave_ws_byte_en_ram.sv
// Single-port-write, synchronous-read word RAM with per-byte write enables.
// Read data appears the cycle after raddr is presented (read-before-write on collision).
module mfp_byte_en_ram
   import mfp_ahb_ram_slave_ws_pkg::*;
#(
   parameter int ADDR_WIDTH = 6
)
(
   input  logic                  clk,
   input  logic                  we,
   input  logic [BYTE_LANES-1:0] be,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [31:0]           wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [31:0]           rdata
);

   logic [31:0] mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (we && be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mfp_ahb_ram_slave_ws.sv
// AHB-Lite RAM slave: 1-cycle data phase plus WAIT_STATES HREADY-low cycles on OKAY,
// two-cycle ERROR response; new address phases are only taken while HREADY is high.
module mfp_ahb_ram_slave_ws
   import mfp_ahb_ram_slave_ws_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int WAIT_STATES = 0
)
(
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic [31:0] HADDR,
   input  logic [2:0]  HBURST,
   input  logic        HMASTLOCK,
   input  logic [3:0]  HPROT,
   input  logic        HSEL,
   input  logic [2:0]  HSIZE,
   input  logic [1:0]  HTRANS,
   input  logic [31:0] HWDATA,
   input  logic        HWRITE,
   input  logic        HREADYIN,
   output logic [31:0] HRDATA,
   output logic        HREADY,
   output logic        HRESP
);

   localparam bit       HAS_WAIT = (WAIT_STATES > 0);
   localparam int       WS_M1    = HAS_WAIT ? WAIT_STATES - 1 : 0;
   localparam logic [2:0] WS_LOAD = WS_M1[2:0];

   logic [1:0]            state, state_nxt;
   logic [2:0]            cnt;
   logic                  d_vld, d_write;
   logic [ADDR_WIDTH+1:0] d_addr;
   logic [2:0]            d_size;
   logic [BYTE_LANES-1:0] d_be, fwd_be;
   logic [31:0]           fwd_dat, rdata_q, ram_q, rd_live;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  accept, a_err, wr_commit, rd_phase, fwd_hit;
   logic                  unused_ok;

   assign unused_ok = &{1'b0, HBURST, HMASTLOCK, HPROT, HADDR[31:ADDR_WIDTH+2], HTRANS[0]};

   assign HREADY    = (state == S_IDLE) || (state == S_ERR2);
   assign HRESP     = (state == S_ERR1) || (state == S_ERR2);
   assign accept    = HSEL & HREADYIN & HTRANS[1] & HREADY;
   assign a_err     = size_err(HADDR[1:0], HSIZE);
   assign d_be      = byte_en(d_addr[1:0], d_size);
   assign wr_commit = d_vld & d_write & (state == S_IDLE);
   assign rd_phase  = d_vld & ~d_write & ((state == S_IDLE) || (state == S_WAIT));

   // A read accepted while the preceding write commits sees pre-write RAM data,
   // so the written lanes are patched in from HWDATA.
   assign fwd_hit = wr_commit & accept & ~HWRITE &
                    (HADDR[ADDR_WIDTH+1:2] == d_addr[ADDR_WIDTH+1:2]);
   assign rd_addr = accept ? HADDR[ADDR_WIDTH+1:2] : d_addr[ADDR_WIDTH+1:2];

   always_comb begin
      rd_live = ram_q;
      for (int i = 0; i < BYTE_LANES; i++) begin
         if (fwd_be[i]) rd_live[8*i +: 8] = fwd_dat[8*i +: 8];
      end
   end

   assign HRDATA = rd_phase ? rd_live : rdata_q;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_ERR2: begin
            if (accept) state_nxt = a_err ? S_ERR1 : (HAS_WAIT ? S_WAIT : S_IDLE);
            else        state_nxt = S_IDLE;
         end
         S_WAIT:  if (cnt == 3'd0) state_nxt = S_IDLE;
         S_ERR1:  state_nxt = S_ERR2;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state   <= S_IDLE;
         cnt     <= 3'd0;
         d_vld   <= 1'b0;
         d_write <= 1'b0;
         d_addr  <= '0;
         d_size  <= 3'd0;
         fwd_be  <= '0;
         fwd_dat <= 32'd0;
         rdata_q <= 32'd0;
      end else begin
         state <= state_nxt;
         if ((state == S_WAIT) && (cnt != 3'd0)) cnt <= cnt - 3'd1;
         else if (accept && !a_err)              cnt <= WS_LOAD;
         if (HREADY) begin
            d_vld <= accept;
            if (accept) begin
               d_addr  <= HADDR[ADDR_WIDTH+1:0];
               d_size  <= HSIZE;
               d_write <= HWRITE;
               fwd_be  <= fwd_hit ? d_be : '0;
               fwd_dat <= HWDATA;
            end
         end
         if (rd_phase) rdata_q <= rd_live;
      end
   end

   mfp_byte_en_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (HCLK),
      .we    (wr_commit),
      .be    (d_be),
      .waddr (d_addr[ADDR_WIDTH+1:2]),
      .wdata (HWDATA),
      .raddr (rd_addr),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_mfp_ahb_ram_slave_ws.sv
// Bench for the AHB RAM slave: a zero-wait and a three-wait instance share one bus,
// driven by a pipelined master with a scoreboard of expected data-phase results.
module tb_mfp_ahb_ram_slave_ws;
   import mfp_ahb_ram_slave_ws_pkg::*;

   typedef struct {
      logic        rd;
      logic        err;
      logic [31:0] dat;
      int          waits;
   } sb_t;

   logic        clk, rst, active, hsel, hwrite, hmastlock;
   logic [31:0] haddr, hwdata, pend_wdata;
   logic [2:0]  hburst, hsize;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        sel0, sel3, ready0, ready3, resp0, resp3;
   logic        hready_bus, resp_bus;
   logic [31:0] rdata0, rdata3, hrdata_bus;
   sb_t         sb[$];
   int          errors = 0;
   int          checks = 0;

   assign sel0       = hsel & ~active;
   assign sel3       = hsel & active;
   assign hready_bus = active ? ready3 : ready0;
   assign resp_bus   = active ? resp3 : resp0;
   assign hrdata_bus = active ? rdata3 : rdata0;

   mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(6), .WAIT_STATES(0)) dut0 (
      .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HBURST(hburst), .HMASTLOCK(hmastlock),
      .HPROT(hprot), .HSEL(sel0), .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata),
      .HWRITE(hwrite), .HREADYIN(hready_bus), .HRDATA(rdata0), .HREADY(ready0), .HRESP(resp0)
   );

   mfp_ahb_ram_slave_ws #(.ADDR_WIDTH(6), .WAIT_STATES(3)) dut3 (
      .HCLK(clk), .HRESET(rst), .HADDR(haddr), .HBURST(hburst), .HMASTLOCK(hmastlock),
      .HPROT(hprot), .HSEL(sel3), .HSIZE(hsize), .HTRANS(htrans), .HWDATA(hwdata),
      .HWRITE(hwrite), .HREADYIN(hready_bus), .HRDATA(rdata3), .HREADY(ready3), .HRESP(resp3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Called at a falling edge: presents one address phase (holding it through
   // HREADY-low cycles) and retires the previous data phase from the scoreboard.
   task automatic ahb(input string tag, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_waits);
      sb_t e;
      int  waits;
      hsel   = 1'b1;
      htrans = trans;
      hwrite = wr;
      haddr  = addr;
      hsize  = size;
      hwdata = pend_wdata;
      waits  = 0;
      while (hready_bus !== 1'b1 && waits < 20) begin
         @(negedge clk);
         waits++;
      end
      if (waits >= 20) chk({tag, "_ready_timeout"}, {31'd0, hready_bus}, 32'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, "_prev_resp"}, {31'd0, resp_bus}, {31'd0, e.err});
         chk({tag, "_prev_waits"}, waits, e.waits);
         if (e.rd && !e.err) chk({tag, "_prev_rdata"}, hrdata_bus, e.dat);
      end
      if (trans[1]) begin
         e.rd    = ~wr;
         e.err   = exp_err;
         e.dat   = exp_rd;
         e.waits = exp_waits;
         sb.push_back(e);
         pend_wdata = wdata;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; active = 1'b0; hsel = 1'b0; htrans = HTRANS_IDLE; hwrite = 1'b0;
      haddr = 32'd0; hsize = HSIZE_WORD; hwdata = 32'd0; hburst = HBURST_SINGLE;
      hmastlock = 1'b0; hprot = 4'b0011; pend_wdata = 32'd0;
      repeat (3) @(negedge clk);
      chk("rst_ready0", {31'd0, ready0}, 32'd1);
      chk("rst_resp0",  {31'd0, resp0},  32'd0);
      chk("rst_rdata0", rdata0, 32'd0);
      chk("rst_ready3", {31'd0, ready3}, 32'd1);
      chk("rst_resp3",  {31'd0, resp3},  32'd0);
      chk("rst_rdata3", rdata3, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // zero wait states
      ahb("w10",   HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      ahb("r10f",  HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      ahb("idle1", HTRANS_IDLE,   1'b0, 32'h0,  HSIZE_WORD, 32'h0, 32'h0, 1'b0, 0);
      ahb("r10",   HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      ahb("w10b",  HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'h11223344, 32'h0, 1'b0, 0);
      ahb("wb13",  HTRANS_NONSEQ, 1'b1, 32'h13, HSIZE_BYTE, 32'hAA000000, 32'h0, 1'b0, 0);
      ahb("rbyte", HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'h0, 32'hAA223344, 1'b0, 0);
      ahb("w20",   HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'hCAFEF00D, 32'h0, 1'b0, 0);
      ahb("r20f",  HTRANS_SEQ,    1'b0, 32'h20, HSIZE_WORD, 32'h0, 32'hCAFEF00D, 1'b0, 0);
      ahb("wh12",  HTRANS_NONSEQ, 1'b1, 32'h12, HSIZE_HALF, 32'hBEEF0000, 32'h0, 1'b0, 0);
      ahb("idle2", HTRANS_IDLE,   1'b0, 32'h0,  HSIZE_WORD, 32'h0, 32'h0, 1'b0, 0);
      ahb("rh10",  HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_HALF, 32'h0, 32'hBEEF3344, 1'b0, 0);
      ahb("w00",   HTRANS_NONSEQ, 1'b1, 32'h00, HSIZE_WORD, 32'h55667788, 32'h0, 1'b0, 0);

      // error responses leave memory untouched
      ahb("eh01",  HTRANS_NONSEQ, 1'b1, 32'h01, HSIZE_HALF, 32'hFFFF0000, 32'h0, 1'b1, 1);
      chk("err1_ready", {31'd0, hready_bus}, 32'd0);
      chk("err1_resp",  {31'd0, resp_bus},   32'd1);
      ahb("r00a",  HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h0, 32'h55667788, 1'b0, 0);
      ahb("es3",   HTRANS_NONSEQ, 1'b1, 32'h00, 3'b011, 32'hFFFFFFFF, 32'h0, 1'b1, 1);
      chk("err1s3_ready", {31'd0, hready_bus}, 32'd0);
      chk("err1s3_resp",  {31'd0, resp_bus},   32'd1);
      ahb("r00b",  HTRANS_NONSEQ, 1'b0, 32'h00, HSIZE_WORD, 32'h0, 32'h55667788, 1'b0, 0);
      ahb("ew22",  HTRANS_NONSEQ, 1'b0, 32'h22, HSIZE_WORD, 32'h0, 32'h0, 1'b1, 1);
      ahb("idle3", HTRANS_IDLE,   1'b0, 32'h0,  HSIZE_WORD, 32'h0, 32'h0, 1'b0, 0);
      chk("sb_empty0", sb.size(), 32'd0);

      // three wait states
      active = 1'b1;
      ahb("ws_w08",  HTRANS_NONSEQ, 1'b1, 32'h08, HSIZE_WORD, 32'h0BADCAFE, 32'h0, 1'b0, 3);
      ahb("ws_r08f", HTRANS_NONSEQ, 1'b0, 32'h08, HSIZE_WORD, 32'h0, 32'h0BADCAFE, 1'b0, 3);
      ahb("ws_r08",  HTRANS_NONSEQ, 1'b0, 32'h08, HSIZE_WORD, 32'h0, 32'h0BADCAFE, 1'b0, 3);
      ahb("ws_idle", HTRANS_IDLE,   1'b0, 32'h0,  HSIZE_WORD, 32'h0, 32'h0, 1'b0, 0);
      chk("ws_hold_rdata", hrdata_bus, 32'h0BADCAFE);

      // reset in the middle of a write's wait states
      ahb("ws_wrst", HTRANS_NONSEQ, 1'b1, 32'h08, HSIZE_WORD, 32'h12345678, 32'h0, 1'b0, 3);
      chk("mid_wait_ready", {31'd0, hready_bus}, 32'd0);
      htrans = HTRANS_IDLE;
      hsel   = 1'b0;
      hwdata = 32'h12345678;
      rst    = 1'b1;
      #1;
      chk("rstmid_ready", {31'd0, hready_bus}, 32'd1);
      chk("rstmid_resp",  {31'd0, resp_bus},   32'd0);
      chk("rstmid_rdata", hrdata_bus, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ahb("ws_rold",  HTRANS_NONSEQ, 1'b0, 32'h08, HSIZE_WORD, 32'h0, 32'h0BADCAFE, 1'b0, 3);
      ahb("ws_idle2", HTRANS_IDLE,   1'b0, 32'h0,  HSIZE_WORD, 32'h0, 32'h0, 1'b0, 0);
      chk("sb_empty3", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mfp_ahb_ram_slave_ws.md
MFP_AHB_RAM_SLAVE_WS -- requirements
Module: mfp_ahb_ram_slave_ws

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 6, giving word-address bits; depth is 2**ADDR_WIDTH 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 0, legal 0..7, giving HREADY-low cycles inserted in every OKAY data phase.
REQ-003 SHALL have port HCLK, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port HRESET, input, 1, reset that is asynchronous and active-high.
REQ-005 SHALL have inputs HADDR 32, HBURST 3, HMASTLOCK 1, HPROT 4, HSEL 1, HSIZE 3, HTRANS 2, HWDATA 32, HWRITE 1, carrying AHB-Lite master signals.
REQ-006 SHALL have input HREADYIN, 1, the bus-level ready; an address phase is accepted only when HSEL & HREADYIN & HTRANS is NONSEQ or SEQ.
REQ-007 SHALL have outputs HRDATA 32 (read data), HREADY 1 (slave ready) and HRESP 1 (0 OKAY, 1 ERROR).
REQ-008 SHALL ignore HBURST, HMASTLOCK and HPROT; IDLE and BUSY transfers get zero-wait OKAY with no memory access.

Function
REQ-009 SHALL register HADDR[ADDR_WIDTH+1:0], HSIZE, HWRITE and a valid flag at every accepted address phase.
REQ-010 SHALL flag ERROR for an accepted transfer if HSIZE > 2, if a halfword has HADDR[0]=1, or if a word has HADDR[1:0]!=0.
REQ-011 SHALL derive byte enables from the registered address and size: byte -> 4'b0001<<A[1:0]; halfword -> A[1]?4'b1100:4'b0011; word -> 4'b1111.
REQ-012 SHALL use FSM states IDLE, WAIT, ERR1 and ERR2.
REQ-013 IDLE: HREADY=1, HRESP=0; accepted OKAY transfer -> WAIT if WAIT_STATES>0, else stays IDLE with data phase completing next cycle; accepted ERROR transfer -> ERR1.
REQ-014 WAIT: HREADY=0, HRESP=0; a 3-bit counter loaded with WAIT_STATES-1 decrements; at zero -> IDLE, and that IDLE cycle completes the data phase.
REQ-015 ERR1: HREADY=0, HRESP=1 -> ERR2; ERR2: HREADY=1, HRESP=1 -> IDLE; no memory write for errored transfers.
REQ-016 SHALL accept a new address phase only in the cycle HREADY=1, so back-to-back pipelined transfers work at any WAIT_STATES.
REQ-017 SHALL commit a write, with its byte enables and HWDATA, only in the data-phase cycle where HREADY=1.
REQ-018 SHALL hold read data stable on HRDATA from the first data-phase cycle until HREADY=1 (registered copy when WAIT_STATES>0).
REQ-019 SHALL forward data for a read accepted in the same cycle that a write commits to the same word: enabled bytes come from HWDATA, the rest from memory.
REQ-020 SHALL drive HRDATA with the last read value in non-read cycles; no X propagation after reset.

Reset
REQ-021 HRESET SHALL asynchronously force FSM=IDLE, HREADY=1, HRESP=0, valid flag=0, counter=0 and HRDATA register=0.
REQ-022 A transfer in flight at reset SHALL be discarded without a memory write; memory contents are not cleared.

Structure
REQ-023 HTRANS/HSIZE/HBURST encodings and FSM state codes SHALL come from the shared AHB-Lite header.
REQ-024 Storage SHALL be one sub-module mfp_byte_en_ram: a synchronous-read, single-write-port RAM with 4 byte-enable lanes, parametrised by ADDR_WIDTH.

Verification
REQ-025 WAIT_STATES=0: write word 0xDEADBEEF at 0x10, then read 0x10 -> HRDATA=0xDEADBEEF one cycle after the read address phase, HREADY always 1.
REQ-026 Byte write 0xAA at 0x13 over word 0x11223344 -> subsequent read 0x10 returns 0xAA223344.
REQ-027 Write 0xCAFEF00D at 0x20 with back-to-back read of 0x20 in the write's data phase -> read returns 0xCAFEF00D (forwarding).
REQ-028 WAIT_STATES=3: single read -> HREADY low exactly 3 cycles, then high with valid data; next pipelined transfer accepted only on that high cycle.
REQ-029 Halfword access at 0x01 -> HREADY=0/HRESP=1, then HREADY=1/HRESP=1, memory unchanged; also HSIZE=3 -> same error.
REQ-030 Assert HRESET mid-WAIT of a write -> outputs at reset values immediately; later read of that address returns the old data.
